// File: rtl/reg_fifo_pkg.sv
// Shared definitions for the shift-register FIFO: stage-select codes and
// count-width helper.
package reg_fifo_pkg;

    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_DIN  = 2'd1;
    localparam logic [1:0] SEL_NEXT = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_fifo_stage.sv
// One FIFO storage stage: a data register plus its occupancy bit.
module reg_fifo_stage
    import reg_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [WIDTH-1:0] next_i,
    input  logic             set_v_i,
    input  logic             clr_v_i,
    output logic [WIDTH-1:0] data_o,
    output logic             v_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             v_q, v_d;

    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        case (sel_i)
            SEL_DIN:  data_d = din_i;
            SEL_NEXT: data_d = next_i;
            default:  data_d = data_q;
        endcase
        if (set_v_i) begin
            v_d = 1'b1;
        end else if (clr_v_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data_q <= '0;
            v_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign data_o = data_q;
    assign v_o    = v_q;

endmodule

// File: rtl/reg_fifo.sv
// Parametrised shift-register FIFO; the head is always stage 0 so dout needs
// no read mux. Flags decode the registered count; error pulses are registered.
module reg_fifo
    import reg_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AF_TH = DEPTH - 1,
    parameter int unsigned AE_TH = 1
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          shift_in,
    input  logic [WIDTH-1:0]              din,
    input  logic                          shift_out,
    output logic [WIDTH-1:0]              dout,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned CW = cnt_width(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("reg_fifo: DEPTH must be at least 2");
    end
    if (AF_TH > DEPTH) begin : g_bad_af
        $error("reg_fifo: AF_TH must not exceed DEPTH");
    end
    if (AE_TH >= DEPTH) begin : g_bad_ae
        $error("reg_fifo: AE_TH must be below DEPTH");
    end

    // Entry DEPTH is a permanently empty virtual stage feeding the last one.
    logic [DEPTH:0][WIDTH-1:0] data;
    logic [DEPTH:0]            v;
    logic [1:0]                sel [DEPTH];
    logic [DEPTH-1:0]          set_v, clr_v;
    logic                      rd, wr;
    logic [CW-1:0]             count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic                      underflow_q, underflow_d;

    assign data[DEPTH] = '0;
    assign v[DEPTH]    = 1'b0;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_TH));
    assign almost_empty = (count_q <= CW'(AE_TH));

    assign rd = shift_out & ~empty;
    assign wr = shift_in & (~full | rd);

    always_comb begin
        sel   = '{default: SEL_HOLD};
        set_v = '0;
        clr_v = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd) begin
                if (v[i+1]) begin
                    sel[i] = SEL_NEXT;
                end else if (wr && (CW'(i) == count_q - CW'(1))) begin
                    sel[i] = SEL_DIN;
                end else begin
                    clr_v[i] = 1'b1;
                end
            end else if (wr && (CW'(i) == count_q)) begin
                sel[i]   = SEL_DIN;
                set_v[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        reg_fifo_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .res     (res),
            .sel_i   (sel[i]),
            .din_i   (din),
            .next_i  (data[i+1]),
            .set_v_i (set_v[i]),
            .clr_v_i (clr_v[i]),
            .data_o  (data[i]),
            .v_o     (v[i])
        );
    end

    always_comb begin
        count_d     = count_q + CW'(wr) - CW'(rd);
        overflow_d  = shift_in & full & ~rd;
        underflow_d = shift_out & empty;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign dout      = data[0];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
